// File: rtl/cfg_regbank_pkg.sv
// cfg_regbank_pkg: address-map helpers shared by the register bank and blocks that name its registers
package cfg_regbank_pkg;
  localparam int RW_BASE = 0;
  function automatic int ro_base(int num_rw);
    return RW_BASE + num_rw;
  endfunction
  function automatic int evt_addr(int num_rw, int num_ro);
    return RW_BASE + num_rw + num_ro;
  endfunction
endpackage

// File: rtl/cfg_evt_reg.sv
// cfg_evt_reg: sticky per-bit event register, set wins over write-1-to-clear, OR-reduced irq
module cfg_evt_reg #(
  parameter int CFG_DW = 32
) (
  input  logic              axi_clk,
  input  logic              axi_rst_n,
  input  logic [CFG_DW-1:0] evt_set,
  input  logic [CFG_DW-1:0] evt_clr,
  output logic [CFG_DW-1:0] evt_q,
  output logic              evt_irq
);
  always_ff @(posedge axi_clk or negedge axi_rst_n)
    if (!axi_rst_n) evt_q <= '0;
    else evt_q <= (evt_q & ~evt_clr) | evt_set;
  assign evt_irq = |evt_q;
endmodule

// File: rtl/cfg_regbank.sv
// cfg_regbank: RW hold registers with strobes and optional pulse mode, RO status words, sticky event register
module cfg_regbank
  import cfg_regbank_pkg::*;
#(
  parameter int CFG_DW = 32,
  parameter int CFG_AW = 5,
  parameter int CFG_NUM_RW = 16,
  parameter int CFG_NUM_RO = 8,
  parameter logic [CFG_NUM_RW-1:0] CFG_PULSE_MASK = '0
) (
  input  logic                         axi_clk,
  input  logic                         axi_rst_n,
  input  logic [CFG_DW-1:0]            cfg_wr_data,
  input  logic [CFG_AW-1:0]            cfg_wr_addr,
  input  logic                         cfg_wr_en,
  input  logic [CFG_AW-1:0]            cfg_rd_addr,
  input  logic                         cfg_rd_en,
  output logic [CFG_DW-1:0]            cfg_rd_data,
  output logic [CFG_NUM_RW*CFG_DW-1:0] hold_data,
  output logic [CFG_NUM_RW-1:0]        hold_en,
  input  logic [CFG_NUM_RO*CFG_DW-1:0] status_in,
  input  logic [CFG_DW-1:0]            evt_in,
  output logic                         evt_irq
);
  localparam int RO_BASE = ro_base(CFG_NUM_RW);
  localparam int EVT_ADDR = evt_addr(CFG_NUM_RW, CFG_NUM_RO);
  logic [CFG_DW-1:0] hold [CFG_NUM_RW];
  logic [CFG_DW-1:0] evt_q, evt_clr, rd_mux;
  genvar i;
  generate
    for (i = 0; i < CFG_NUM_RW; i++) begin : g_rw
      logic hit;
      assign hit = cfg_wr_en && cfg_wr_addr == CFG_AW'(RW_BASE + i);
      always_ff @(posedge axi_clk or negedge axi_rst_n)
        if (!axi_rst_n) begin
          hold[i] <= '0;
          hold_en[i] <= 1'b0;
        end else begin
          hold[i] <= hit ? cfg_wr_data : (CFG_PULSE_MASK[i] ? '0 : hold[i]);
          hold_en[i] <= hit;
        end
      assign hold_data[i*CFG_DW +: CFG_DW] = hold[i];
    end
  endgenerate
  assign evt_clr = (cfg_wr_en && cfg_wr_addr == CFG_AW'(EVT_ADDR)) ? cfg_wr_data : '0;
  cfg_evt_reg #(.CFG_DW(CFG_DW)) u_evt (
    .axi_clk  (axi_clk),
    .axi_rst_n(axi_rst_n),
    .evt_set  (evt_in),
    .evt_clr  (evt_clr),
    .evt_q    (evt_q),
    .evt_irq  (evt_irq)
  );
  always_comb begin
    rd_mux = cfg_rd_addr == CFG_AW'(EVT_ADDR) ? evt_q : '0;
    for (int r = 0; r < CFG_NUM_RW; r++)
      if (cfg_rd_addr == CFG_AW'(RW_BASE + r)) rd_mux = hold[r];
    for (int s = 0; s < CFG_NUM_RO; s++)
      if (cfg_rd_addr == CFG_AW'(RO_BASE + s)) rd_mux = status_in[s*CFG_DW +: CFG_DW];
  end
  always_ff @(posedge axi_clk or negedge axi_rst_n)
    if (!axi_rst_n) cfg_rd_data <= '0;
    else cfg_rd_data <= cfg_rd_en ? rd_mux : '0;
endmodule

// File: tb/tb_cfg_regbank.sv
// tb_cfg_regbank: scoreboard bench for cfg_regbank with one pulse register at address 0
module tb_cfg_regbank;
  localparam int DW = 32, AW = 5, NRW = 16, NRO = 8, EVT = 24;
  logic axi_clk = 1'b0, axi_rst_n = 1'b0;
  logic [DW-1:0] cfg_wr_data = '0, evt_in = '0, cfg_rd_data;
  logic [AW-1:0] cfg_wr_addr = '0, cfg_rd_addr = '0;
  logic cfg_wr_en = 1'b0, cfg_rd_en = 1'b0, evt_irq;
  logic [NRW*DW-1:0] hold_data, exp_hold = '0;
  logic [NRW-1:0] hold_en;
  logic [NRO*DW-1:0] status_in = '0;
  logic [DW-1:0] sb [$];
  int n_run = 0, n_fail = 0;

  cfg_regbank #(.CFG_DW(DW), .CFG_AW(AW), .CFG_NUM_RW(NRW), .CFG_NUM_RO(NRO),
                .CFG_PULSE_MASK(16'h0001)) dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_en(cfg_wr_en),
    .cfg_rd_addr(cfg_rd_addr), .cfg_rd_en(cfg_rd_en), .cfg_rd_data(cfg_rd_data),
    .hold_data(hold_data), .hold_en(hold_en), .status_in(status_in),
    .evt_in(evt_in), .evt_irq(evt_irq)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge axi_clk);
    cfg_wr_en = 1'b1;
    cfg_wr_addr = a;
    cfg_wr_data = d;
  endtask

  task automatic idle();
    @(negedge axi_clk);
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;
    evt_in = '0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    @(negedge axi_clk);
    cfg_rd_en = 1'b1;
    cfg_rd_addr = a;
    sb.push_back(exp);
    @(negedge axi_clk);
    cfg_rd_en = 1'b0;
  endtask

  initial begin
    logic was;
    forever begin
      @(posedge axi_clk);
      was = cfg_rd_en && axi_rst_n;
      #1;
      if (was) begin
        if (sb.size() != 0) check("rd_data", cfg_rd_data, sb.pop_front());
        else begin
          n_fail++;
          $display("FAIL rd_unexpected: got 0x%08h with empty scoreboard", cfg_rd_data);
        end
      end
    end
  end

  initial begin
    status_in[2*DW +: DW] = 32'h12345678;
    repeat (3) tick();
    check("rst_hold", {31'd0, hold_data == '0}, 1);
    check("rst_hold_en", {16'd0, hold_en}, 0);
    check("rst_irq", {31'd0, evt_irq}, 0);
    check("rst_rd_data", cfg_rd_data, 0);
    @(negedge axi_clk);
    axi_rst_n = 1'b1;
    rd(0, 0);
    rd(16, 0);
    rd(31, 0);
    check("irq_idle", {31'd0, evt_irq}, 0);
    wr(3, 32'hDEADBEEF);
    exp_hold[3*DW +: DW] = 32'hDEADBEEF;
    tick();
    check("wr3_hold_en", {16'd0, hold_en}, 32'h0008);
    check("wr3_word", hold_data[3*DW +: DW], 32'hDEADBEEF);
    idle();
    tick();
    check("wr3_hold_en_off", {16'd0, hold_en}, 0);
    rd(3, 32'hDEADBEEF);
    wr(0, 32'h1);
    tick();
    check("pulse_on", hold_data[0 +: DW], 1);
    idle();
    tick();
    check("pulse_off", hold_data[0 +: DW], 0);
    wr(0, 32'h1);
    tick();
    check("pulse_b2b_1", hold_data[0 +: DW], 1);
    wr(0, 32'h1);
    tick();
    check("pulse_b2b_2", hold_data[0 +: DW], 1);
    idle();
    tick();
    check("pulse_b2b_off", hold_data[0 +: DW], 0);
    wr(5, 32'h000000AA);
    cfg_rd_en = 1'b1;
    cfg_rd_addr = 5;
    sb.push_back(0);
    exp_hold[5*DW +: DW] = 32'hAA;
    idle();
    rd(5, 32'hAA);
    wr(18, 32'hFFFFFFFF);
    tick();
    check("ro_wr_hold_en", {16'd0, hold_en}, 0);
    idle();
    check("ro_wr_hold", {31'd0, hold_data == exp_hold}, 1);
    rd(18, 32'h12345678);
    wr(25, 32'hFFFFFFFF);
    idle();
    check("unmapped_wr_hold", {31'd0, hold_data == exp_hold}, 1);
    rd(25, 0);
    rd(EVT, 0);
    @(negedge axi_clk);
    evt_in = 32'h5;
    tick();
    check("evt_irq_set", {31'd0, evt_irq}, 1);
    idle();
    rd(EVT, 32'h5);
    wr(EVT, 32'h1);
    evt_in = 32'h1;
    idle();
    rd(EVT, 32'h5);
    check("evt_irq_kept", {31'd0, evt_irq}, 1);
    wr(EVT, 32'h4);
    idle();
    rd(EVT, 32'h1);
    wr(EVT, 32'h5);
    tick();
    check("evt_irq_clr", {31'd0, evt_irq}, 0);
    idle();
    rd(EVT, 0);
    wr(1, 32'hCAFEF00D);
    #2 axi_rst_n = 1'b0;
    tick();
    check("rst_mid_hold_en", {16'd0, hold_en}, 0);
    check("rst_mid_word1", hold_data[DW +: DW], 0);
    idle();
    axi_rst_n = 1'b1;
    tick();
    check("rst_after_hold_en", {16'd0, hold_en}, 0);
    rd(1, 0);
    rd(3, 0);
    repeat (3) tick();
    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
